// File: rtl/slow_multiplication.sv
// rtl/slow_multiplication.sv - sequential unsigned shift-and-add multiplier, one partial product per clock
module slow_multiplication #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     sum;
    logic               c;

    always_comb begin
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{p[0]}}};
        c   = sum[WIDTH];
    end

    assign product = p;

    // The add's carry becomes the new MSB after the shift, so no product bit is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            p     <= '0;
            count <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        m     <= A;
                        p     <= {{WIDTH{1'b0}}, B};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p     <= {c, sum[WIDTH-1:0], p[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
